// File: rtl/vga_pkg.sv
// Shared VGA timing constants, derived totals and datapath types for the
// 640x480@60 game display pipeline.
package vga_pkg;

    // Standard 640x480@60 horizontal timing, in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Standard 640x480@60 vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // 24-bit renderer colour, packed as {red, green, blue}
    typedef logic [23:0] color_t;

    // Decoded scan state carried alongside the colour through the pipeline.
    // hs/vs are logical "sync asserted" flags; polarity is applied at the pins.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_t;

    // Pattern held in the delay line while no real pixel has reached it yet
    localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

    // Pixels per line including blanking
    function automatic int hTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking
    function automatic int vTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that delays the decoded {active, hs, vs}
// flags by DEPTH pixel strobes so they stay aligned with delayed colour.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  sync_t i_sync,
    output sync_t o_sync
);

    sync_t r_stage [DEPTH];

    // Shift one stage per pixel strobe; reset fills the line with the idle pattern
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= SYNC_IDLE;
            end
        end else if (i_en) begin
            r_stage[0] <= i_sync;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// VGA pixel-timing generator and registered output stage. Divides the system
// clock into a pixel strobe, runs the scan counters that feed the renderers,
// and registers RGB, blank and sync aligned to the renderer colour.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        VGA_Ready,
    output logic        frame_end,
    input  logic [23:0] color_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank
);

    localparam int H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] X_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] X_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] Y_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_divNext;
    logic             r_ready;
    logic [15:0]      r_x;
    logic [15:0]      r_y;
    sync_t            w_decode;
    sync_t            w_delayed;
    color_t           w_colorDelayed;
    color_t           r_rgb;
    logic             r_blank;
    logic             r_hs;
    logic             r_vs;

    // Next divider value, wrapping after CLK_DIV-1
    always_comb begin
        w_divNext = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end

    // Clock divider; the strobe is registered from the next divider value so it
    // is high exactly while the divider sits at its last count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_div   <= w_divNext;
            r_ready <= (w_divNext == DIV_LAST);
        end
    end

    // Scan counters advance on the strobe; line and frame wraps share that edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_ready) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 16'd1;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end
    end

    // Decode visible area and sync windows from the current scan position
    always_comb begin
        w_decode        = SYNC_IDLE;
        w_decode.active = (r_x < X_ACT) && (r_y < Y_ACT);
        w_decode.hs     = (r_x >= HS_START) && (r_x < HS_END);
        w_decode.vs     = (r_y >= VS_START) && (r_y < VS_END);
    end

    generate
        if (PIPE_DELAY > 1) begin : g_pipe
            color_t r_colorPipe [PIPE_DELAY-1];

            vga_sync_delay #(
                .DEPTH (PIPE_DELAY - 1)
            ) u_syncDelay (
                .clk    (clk),
                .rst    (rst),
                .i_en   (r_ready),
                .i_sync (w_decode),
                .o_sync (w_delayed)
            );

            // Colour delay line matching the sync/blank delay, one stage per strobe
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE_DELAY - 1; i++) begin
                        r_colorPipe[i] <= '0;
                    end
                end else if (r_ready) begin
                    r_colorPipe[0] <= color_in;
                    for (int i = 1; i < PIPE_DELAY - 1; i++) begin
                        r_colorPipe[i] <= r_colorPipe[i-1];
                    end
                end
            end

            assign w_colorDelayed = r_colorPipe[PIPE_DELAY-2];
        end else begin : g_direct
            assign w_delayed      = w_decode;
            assign w_colorDelayed = color_in;
        end
    endgenerate

    // Output register: blank forces black, sync polarity applied here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb   <= '0;
            r_blank <= 1'b1;
            r_hs    <= ~SYNC_POL;
            r_vs    <= ~SYNC_POL;
        end else if (r_ready) begin
            r_rgb   <= w_delayed.active ? w_colorDelayed : '0;
            r_blank <= ~w_delayed.active;
            r_hs    <= w_delayed.hs ? SYNC_POL : ~SYNC_POL;
            r_vs    <= w_delayed.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign pixel_x   = r_x;
    assign pixel_y   = r_y;
    assign VGA_Ready = r_ready;
    assign frame_end = r_ready && (r_x == X_LAST) && (r_y == Y_LAST);
    assign vga_r     = r_rgb[23:16];
    assign vga_g     = r_rgb[15:8];
    assign vga_b     = r_rgb[7:0];
    assign vga_hs    = r_hs;
    assign vga_vs    = r_vs;
    assign vga_blank = r_blank;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a full-size 640x480 instance with one-pixel
// latency, and a tiny-timing instance with three-pixel latency and
// active-high sync so that frame wraps fit in a short run.
module tb_vga_timing_out;

    typedef struct packed {
        int   hA;
        int   hF;
        int   hS;
        int   hB;
        int   vA;
        int   vF;
        int   vS;
        int   vB;
        logic pol;
        int   dly;
    } tcfg_t;

    localparam tcfg_t CFG_A = '{hA: 640, hF: 16, hS: 96, hB: 48,
                                vA: 480, vF: 10, vS: 2, vB: 33,
                                pol: 1'b0, dly: 1};
    localparam tcfg_t CFG_B = '{hA: 8, hF: 2, hS: 3, hB: 2,
                                vA: 4, vF: 1, vS: 2, vB: 1,
                                pol: 1'b1, dly: 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] colorA = '0;
    logic [23:0] colorB = '0;

    logic [15:0] xA, yA, xB, yB;
    logic        readyA, readyB, feA, feB;
    logic [7:0]  rA, gA, bA, rB, gB, bB;
    logic        hsA, vsA, blankA, hsB, vsB, blankB;
    logic [31:0] outA, outB;

    int total = 0;
    int bad   = 0;
    int hsLowA;
    int firstHsLowA;
    int frameEndCountB;

    vga_timing_out u_dutA (
        .clk       (clk),
        .rst       (rst),
        .pixel_x   (xA),
        .pixel_y   (yA),
        .VGA_Ready (readyA),
        .frame_end (feA),
        .color_in  (colorA),
        .vga_r     (rA),
        .vga_g     (gA),
        .vga_b     (bA),
        .vga_hs    (hsA),
        .vga_vs    (vsA),
        .vga_blank (blankA)
    );

    vga_timing_out #(
        .CLK_DIV    (4),
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .SYNC_POL   (1'b1),
        .PIPE_DELAY (3)
    ) u_dutB (
        .clk       (clk),
        .rst       (rst),
        .pixel_x   (xB),
        .pixel_y   (yB),
        .VGA_Ready (readyB),
        .frame_end (feB),
        .color_in  (colorB),
        .vga_r     (rB),
        .vga_g     (gB),
        .vga_b     (bB),
        .vga_hs    (hsB),
        .vga_vs    (vsB),
        .vga_blank (blankB)
    );

    assign outA = {5'b0, rA, gA, bA, blankA, hsA, vsA};
    assign outB = {5'b0, rB, gB, bB, blankB, hsB, vsB};

    always #5 clk = ~clk;

    // Renderer stand-ins: colour follows the scan position shown by each DUT
    always @(negedge clk) begin
        colorA = {xA[7:0], yA[7:0], 8'hA5};
        colorB = {xB[7:0], yB[7:0], 8'hA5};
    end

    // Expected {rgb, blank, hs, vs} after p strobes for a given timing/latency
    function automatic logic [31:0] expOut(input tcfg_t c, input int p);
        int q, x, y, hT, vT;
        logic act, hs, vs;
        logic [7:0] xb, yb;
        if (p < c.dly) begin
            return {5'b0, 24'h0, 1'b1, ~c.pol, ~c.pol};
        end
        q   = p - c.dly;
        hT  = c.hA + c.hF + c.hS + c.hB;
        vT  = c.vA + c.vF + c.vS + c.vB;
        x   = q % hT;
        y   = (q / hT) % vT;
        xb  = x[7:0];
        yb  = y[7:0];
        act = (x < c.hA) && (y < c.vA);
        hs  = (x >= c.hA + c.hF) && (x < c.hA + c.hF + c.hS);
        vs  = (y >= c.vA + c.vF) && (y < c.vA + c.vF + c.vS);
        return {5'b0, act ? {xb, yb, 8'hA5} : 24'h0, ~act,
                hs ? c.pol : ~c.pol, vs ? c.pol : ~c.pol};
    endfunction

    function automatic int expX(input tcfg_t c, input int p);
        return p % (c.hA + c.hF + c.hS + c.hB);
    endfunction

    function automatic int expY(input tcfg_t c, input int p);
        return (p / (c.hA + c.hF + c.hS + c.hB)) % (c.vA + c.vF + c.vS + c.vB);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare one DUT against the model after n clk edges since reset release
    task automatic checkDut(input string name, input tcfg_t c, input int n,
                            input logic rdy, input logic [15:0] x, input logic [15:0] y,
                            input logic fe, input logic [31:0] outs);
        int   p;
        logic expRdy, expFe;
        p      = n / 4;
        expRdy = (n % 4 == 3);
        expFe  = expRdy && (expX(c, p) == c.hA + c.hF + c.hS + c.hB - 1)
                        && (expY(c, p) == c.vA + c.vF + c.vS + c.vB - 1);
        checkOutput({name, ".ready"}, 32'(rdy), 32'(expRdy));
        checkOutput({name, ".x"}, 32'(x), 32'(expX(c, p)));
        checkOutput({name, ".y"}, 32'(y), 32'(expY(c, p)));
        checkOutput({name, ".frame_end"}, 32'(fe), 32'(expFe));
        checkOutput({name, ".outputs"}, outs, expOut(c, p));
    endtask

    task automatic checkResetValues(input string tag);
        checkDut({"A.", tag}, CFG_A, 0, readyA, xA, yA, feA, outA);
        checkDut({"B.", tag}, CFG_B, 0, readyB, xB, yB, feB, outB);
    endtask

    // Run nClk clocks after reset release, checking both DUTs at every negedge
    task automatic applyStimulus(input int nClk);
        hsLowA         = 0;
        firstHsLowA    = -1;
        frameEndCountB = 0;
        for (int n = 1; n <= nClk; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkDut("A", CFG_A, n, readyA, xA, yA, feA, outA);
            checkDut("B", CFG_B, n, readyB, xB, yB, feB, outB);
            if ((n % 4 == 0) && (n / 4 >= 1) && (n / 4 <= 800) && (hsA == 1'b0)) begin
                hsLowA++;
                if (firstHsLowA < 0) firstHsLowA = n / 4;
            end
            if (feB) frameEndCountB++;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("por");

        rst = 1'b1;
        applyStimulus(10801);
        checkOutput("A.hsLowCount", 32'(hsLowA), 32'd96);
        checkOutput("A.hsFirstLowStrobe", 32'(firstHsLowA), 32'd657);
        checkOutput("B.frameEndCount", 32'(frameEndCountB), 32'd22);
        checkOutput("A.preResetX", 32'(xA), 32'd300);

        #2 rst = 1'b0;
        #1 checkResetValues("midReset");

        repeat (2) @(negedge clk);
        checkResetValues("heldReset");
        rst = 1'b1;
        applyStimulus(3300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
